// File: rtl/fmul_byte_seq.sv
// fmul_byte_seq: byte-stream sequencer around an external combinational
// single-precision multiplier. Operand A and operand B are each assembled
// from four input bytes and driven on mul_a/mul_b. After CALC_CYCLES the
// block captures mul_out and returns it as four output bytes.
// Optional macro FMUL_SEQ_FLAGS_EN appends a fifth status byte after the
// result bytes: bit0 NaN, bit1 Inf, bit2 zero, bit3 sign.
module fmul_byte_seq #(
  parameter int MSB_FIRST   = 0,
  parameter int CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SEND   = 2'd3
  } state_t;

`ifdef FMUL_SEQ_FLAGS_EN
  localparam logic [2:0] LAST_OUT = 3'd4;
`else
  localparam logic [2:0] LAST_OUT = 3'd3;
`endif

  // Reversing byte order is a 2-bit inversion of the lane index (3-cnt == ~cnt).
  localparam logic [1:0] LANE_FLIP = (MSB_FIRST != 0) ? 2'b11 : 2'b00;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  lane;
  logic        in_xfer;
  logic        out_xfer;

  assign lane      = cnt_q[1:0] ^ LANE_FLIP;
  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid = (state_q == SEND);
  assign busy      = !((state_q == LOAD_A) && (cnt_q == 3'd0));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign mul_a     = a_q;
  assign mul_b     = b_q;

`ifdef FMUL_SEQ_FLAGS_EN
  logic [7:0] flags;
  logic       exp_all_ones;
  logic       man_zero;

  assign exp_all_ones = &res_q[30:23];
  assign man_zero     = ~|res_q[22:0];
  assign flags        = {4'b0000, res_q[31], ~|res_q[30:0],
                         exp_all_ones && man_zero, exp_all_ones && !man_zero};
`endif

  // State, counters and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      wait_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic; flush overrides any transfer and leaves data registers intact.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    if (flush) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (in_xfer) begin
            a_d[{lane, 3'b000} +: 8] = in_data;
            if (cnt_q == 3'd3) begin
              cnt_d   = '0;
              state_d = LOAD_B;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            b_d[{lane, 3'b000} +: 8] = in_data;
            if (cnt_q == 3'd3) begin
              cnt_d   = '0;
              wait_d  = 4'(CALC_CYCLES - 1);
              state_d = CALC;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        CALC: begin
          if (wait_q == 4'd0) begin
            res_d   = mul_out;
            state_d = SEND;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
        SEND: begin
          if (out_xfer) begin
            if (cnt_q == LAST_OUT) begin
              cnt_d   = '0;
              state_d = LOAD_A;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output byte select: result lanes in stream order, status byte last.
  always_comb begin
    out_data = '0;
    if (state_q == SEND) begin
`ifdef FMUL_SEQ_FLAGS_EN
      if (cnt_q == 3'd4) begin
        out_data = flags;
      end else begin
        out_data = res_q[{lane, 3'b000} +: 8];
      end
`else
      out_data = res_q[{lane, 3'b000} +: 8];
`endif
    end
  end

endmodule
